// File: rtl/alu_drv_pkg.sv
// alu_drv_pkg
//   Shared definitions for the 74181-style ALU operation driver.
//   - FSM state encodings for the driver (idle / drive / resp)
//   - Select/mode codes for the common operations a sequencer issues
//   - Helper that computes the settle-counter load value
package alu_drv_pkg;

    // Driver FSM state encodings
    typedef logic [1:0] drv_state_t;
    localparam drv_state_t IDLE  = 2'd0;
    localparam drv_state_t DRIVE = 2'd1;
    localparam drv_state_t RESP  = 2'd2;

    // Function select / mode pairs for frequently used ALU operations
    localparam logic [3:0] SEL_ADD  = 4'h9;
    localparam logic       MODE_ADD = 1'b0;
    localparam logic [3:0] SEL_SUB  = 4'h6;
    localparam logic       MODE_SUB = 1'b0;
    localparam logic [3:0] SEL_XOR  = 4'h6;
    localparam logic       MODE_XOR = 1'b1;
    localparam logic [3:0] SEL_AND  = 4'hB;
    localparam logic       MODE_AND = 1'b1;

    // The counter is loaded with settle-1 so that the sample lands exactly
    // settle edges after acceptance (a load of 0 samples on the next edge).
    function automatic logic [3:0] settle_load(input int settle);
        return 4'(settle - 1);
    endfunction

endpackage

// File: rtl/alu_op_driver.sv
// alu_op_driver
//   Initiator for an 8-bit 74181-style combinational ALU. Accepts one
//   operation over a valid/ready request channel, holds the operands on the
//   ALU inputs, waits SETTLE cycles, samples the ALU results and presents
//   them on a valid/ready response channel. Requests are not queued.
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid / req_ready            request handshake
//   req_in1, req_in2, req_s,
//   req_m, req_cin                   requested operands and controls
//   alu_in1, alu_in2, alu_s,
//   alu_m, alu_cin                   registered drive to the ALU
//   alu_out, alu_cout, alu_aeb       ALU results
//   rsp_valid / rsp_ready            response handshake
//   rsp_out, rsp_cout, rsp_aeb       captured ALU results
//   op_count                         completed responses, wraps
module alu_op_driver
    import alu_drv_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SEL_W  = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_in1,
    input  logic [WIDTH-1:0] req_in2,
    input  logic [SEL_W-1:0] req_s,
    input  logic             req_m,
    input  logic             req_cin,

    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [SEL_W-1:0] alu_s,
    output logic             alu_m,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    input  logic             alu_aeb,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_cout,
    output logic             rsp_aeb,

    output logic [CNT_W-1:0] op_count
);

    localparam logic [3:0] SETTLE_LOAD = settle_load(SETTLE);

    drv_state_t state;
    logic [3:0] settle_cnt;

    // Ready is gated by rst_n so no request can be taken while reset is held.
    assign req_ready = rst_n && (state == IDLE);

    // Main FSM: accept a request, wait out the ALU settle time, capture the
    // results, then hold them until the consumer takes them. The alu_*
    // registers are only written on acceptance so they keep the last
    // operation's values between requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_s      <= '0;
            alu_m      <= 1'b0;
            alu_cin    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_out    <= '0;
            rsp_cout   <= 1'b0;
            rsp_aeb    <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_in1    <= req_in1;
                        alu_in2    <= req_in2;
                        alu_s      <= req_s;
                        alu_m      <= req_m;
                        alu_cin    <= req_cin;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        rsp_out   <= alu_out;
                        rsp_cout  <= alu_cout;
                        rsp_aeb   <= alu_aeb;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_driver.sv
// tb_alu_op_driver
//   Directed bench for alu_op_driver. Three instances share the reset and
//   request operand buses but have their own handshakes and ALU result
//   inputs, so each can run at a different settle time / counter width:
//     a: SETTLE=1, CNT_W=16  (single op, backpressure, carry/equality)
//     b: SETTLE=3, CNT_W=16  (late-settling ALU output)
//     c: SETTLE=4, CNT_W=4   (reset mid-drive, counter wrap)
module tb_alu_op_driver;
    import alu_drv_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] req_in1, req_in2;
    logic [3:0] req_s;
    logic       req_m, req_cin;

    logic       req_valid_a, req_ready_a, rsp_ready_a, rsp_valid_a;
    logic [7:0] alu_in1_a, alu_in2_a, alu_out_a, rsp_out_a;
    logic [3:0] alu_s_a;
    logic       alu_m_a, alu_cin_a, alu_cout_a, alu_aeb_a, rsp_cout_a, rsp_aeb_a;
    logic [15:0] op_count_a;

    logic       req_valid_b, req_ready_b, rsp_ready_b, rsp_valid_b;
    logic [7:0] alu_in1_b, alu_in2_b, alu_out_b, rsp_out_b;
    logic [3:0] alu_s_b;
    logic       alu_m_b, alu_cin_b, alu_cout_b, alu_aeb_b, rsp_cout_b, rsp_aeb_b;
    logic [15:0] op_count_b;

    logic       req_valid_c, req_ready_c, rsp_ready_c, rsp_valid_c;
    logic [7:0] alu_in1_c, alu_in2_c, alu_out_c, rsp_out_c;
    logic [3:0] alu_s_c;
    logic       alu_m_c, alu_cin_c, alu_cout_c, alu_aeb_c, rsp_cout_c, rsp_aeb_c;
    logic [3:0] op_count_c;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_op_driver #(.WIDTH(8), .SEL_W(4), .SETTLE(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_in1(req_in1), .req_in2(req_in2), .req_s(req_s), .req_m(req_m), .req_cin(req_cin),
        .alu_in1(alu_in1_a), .alu_in2(alu_in2_a), .alu_s(alu_s_a), .alu_m(alu_m_a), .alu_cin(alu_cin_a),
        .alu_out(alu_out_a), .alu_cout(alu_cout_a), .alu_aeb(alu_aeb_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
        .rsp_out(rsp_out_a), .rsp_cout(rsp_cout_a), .rsp_aeb(rsp_aeb_a),
        .op_count(op_count_a)
    );

    alu_op_driver #(.WIDTH(8), .SEL_W(4), .SETTLE(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_in1(req_in1), .req_in2(req_in2), .req_s(req_s), .req_m(req_m), .req_cin(req_cin),
        .alu_in1(alu_in1_b), .alu_in2(alu_in2_b), .alu_s(alu_s_b), .alu_m(alu_m_b), .alu_cin(alu_cin_b),
        .alu_out(alu_out_b), .alu_cout(alu_cout_b), .alu_aeb(alu_aeb_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_out(rsp_out_b), .rsp_cout(rsp_cout_b), .rsp_aeb(rsp_aeb_b),
        .op_count(op_count_b)
    );

    alu_op_driver #(.WIDTH(8), .SEL_W(4), .SETTLE(4), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_c), .req_ready(req_ready_c),
        .req_in1(req_in1), .req_in2(req_in2), .req_s(req_s), .req_m(req_m), .req_cin(req_cin),
        .alu_in1(alu_in1_c), .alu_in2(alu_in2_c), .alu_s(alu_s_c), .alu_m(alu_m_c), .alu_cin(alu_cin_c),
        .alu_out(alu_out_c), .alu_cout(alu_cout_c), .alu_aeb(alu_aeb_c),
        .rsp_valid(rsp_valid_c), .rsp_ready(rsp_ready_c),
        .rsp_out(rsp_out_c), .rsp_cout(rsp_cout_c), .rsp_aeb(rsp_aeb_c),
        .op_count(op_count_c)
    );

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put an operation on the shared request operand bus.
    task automatic applyStimulus(input logic [7:0] in1, input logic [7:0] in2,
                                 input logic [3:0] s, input logic m, input logic cin);
        req_in1 = in1;
        req_in2 = in2;
        req_s   = s;
        req_m   = m;
        req_cin = cin;
    endtask

    // One comparison: immediate assertion, failures counted and reported.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid_a = 0; rsp_ready_a = 0; alu_out_a = 0; alu_cout_a = 0; alu_aeb_a = 0;
        req_valid_b = 0; rsp_ready_b = 0; alu_out_b = 0; alu_cout_b = 0; alu_aeb_b = 0;
        req_valid_c = 0; rsp_ready_c = 0; alu_out_c = 0; alu_cout_c = 0; alu_aeb_c = 0;
        applyStimulus(8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
        #1;
        tick();
        tick();

        // Reset state
        checkOutput("rst_req_ready", 16'(req_ready_a), 16'h0);
        checkOutput("rst_alu_in1", 16'(alu_in1_a), 16'h0);
        checkOutput("rst_rsp_valid", 16'(rsp_valid_a), 16'h0);
        checkOutput("rst_rsp_out", 16'(rsp_out_a), 16'h0);
        checkOutput("rst_op_count", op_count_a, 16'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_req_ready", 16'(req_ready_a), 16'h1);

        // Single add, SETTLE=1
        applyStimulus(8'h3C, 8'h05, SEL_ADD, MODE_ADD, 1'b0);
        alu_out_a = 8'h41; alu_cout_a = 1'b0; alu_aeb_a = 1'b0;
        req_valid_a = 1'b1;
        tick();
        req_valid_a = 1'b0;
        checkOutput("add_alu_in1", 16'(alu_in1_a), 16'h3C);
        checkOutput("add_alu_in2", 16'(alu_in2_a), 16'h05);
        checkOutput("add_alu_s", 16'(alu_s_a), 16'h9);
        checkOutput("add_req_ready_busy", 16'(req_ready_a), 16'h0);
        checkOutput("add_rsp_valid_e0", 16'(rsp_valid_a), 16'h0);
        tick();
        checkOutput("add_rsp_valid_e1", 16'(rsp_valid_a), 16'h1);
        checkOutput("add_rsp_out", 16'(rsp_out_a), 16'h41);
        checkOutput("add_rsp_cout", 16'(rsp_cout_a), 16'h0);
        rsp_ready_a = 1'b1;
        tick();
        rsp_ready_a = 1'b0;
        checkOutput("add_rsp_valid_done", 16'(rsp_valid_a), 16'h0);
        checkOutput("add_op_count", op_count_a, 16'h1);
        checkOutput("add_req_ready_idle", 16'(req_ready_a), 16'h1);

        // Carry out, then backpressure with a competing request
        applyStimulus(8'hFF, 8'h01, SEL_ADD, MODE_ADD, 1'b0);
        alu_out_a = 8'h00; alu_cout_a = 1'b1; alu_aeb_a = 1'b0;
        req_valid_a = 1'b1;
        tick();
        applyStimulus(8'h55, 8'h55, SEL_SUB, MODE_SUB, 1'b1);
        tick();
        checkOutput("carry_rsp_valid", 16'(rsp_valid_a), 16'h1);
        checkOutput("carry_rsp_out", 16'(rsp_out_a), 16'h00);
        checkOutput("carry_rsp_cout", 16'(rsp_cout_a), 16'h1);
        checkOutput("carry_rsp_aeb", 16'(rsp_aeb_a), 16'h0);
        alu_out_a = 8'hAA; alu_cout_a = 1'b0; alu_aeb_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_rsp_valid", 16'(rsp_valid_a), 16'h1);
            checkOutput("bp_rsp_out", 16'(rsp_out_a), 16'h00);
            checkOutput("bp_rsp_cout", 16'(rsp_cout_a), 16'h1);
            checkOutput("bp_req_ready", 16'(req_ready_a), 16'h0);
            checkOutput("bp_alu_in1", 16'(alu_in1_a), 16'hFF);
        end
        rsp_ready_a = 1'b1;
        tick();
        rsp_ready_a = 1'b0;
        checkOutput("bp_op_count", op_count_a, 16'h2);
        checkOutput("bp_alu_hold", 16'(alu_in1_a), 16'hFF);
        checkOutput("bp_req_ready_idle", 16'(req_ready_a), 16'h1);

        // Subtract of equal operands accepted from IDLE
        alu_out_a = 8'h00; alu_cout_a = 1'b1; alu_aeb_a = 1'b1;
        tick();
        req_valid_a = 1'b0;
        checkOutput("sub_alu_in1", 16'(alu_in1_a), 16'h55);
        checkOutput("sub_alu_s", 16'(alu_s_a), 16'h6);
        checkOutput("sub_alu_cin", 16'(alu_cin_a), 16'h1);
        tick();
        checkOutput("sub_rsp_aeb", 16'(rsp_aeb_a), 16'h1);
        rsp_ready_a = 1'b1;
        tick();
        rsp_ready_a = 1'b0;
        checkOutput("sub_op_count", op_count_a, 16'h3);

        // SETTLE=3: ALU output only becomes valid two cycles after E0
        applyStimulus(8'h12, 8'h34, SEL_XOR, MODE_XOR, 1'b0);
        alu_out_b = 8'h00;
        req_valid_b = 1'b1;
        tick();
        req_valid_b = 1'b0;
        checkOutput("s3_alu_m", 16'(alu_m_b), 16'h1);
        tick();
        checkOutput("s3_rsp_valid_e1", 16'(rsp_valid_b), 16'h0);
        tick();
        checkOutput("s3_rsp_valid_e2", 16'(rsp_valid_b), 16'h0);
        alu_out_b = 8'hFF;
        tick();
        checkOutput("s3_rsp_valid_e3", 16'(rsp_valid_b), 16'h1);
        checkOutput("s3_rsp_out", 16'(rsp_out_b), 16'hFF);
        rsp_ready_b = 1'b1;
        tick();
        rsp_ready_b = 1'b0;
        checkOutput("s3_op_count", op_count_b, 16'h1);

        // Reset while instance c is in DRIVE
        applyStimulus(8'h77, 8'h11, SEL_AND, MODE_AND, 1'b0);
        alu_out_c = 8'h5A;
        req_valid_c = 1'b1;
        tick();
        req_valid_c = 1'b0;
        tick();
        checkOutput("rd_alu_in1_pre", 16'(alu_in1_c), 16'h77);
        rst_n = 1'b0;
        tick();
        checkOutput("rd_rsp_valid", 16'(rsp_valid_c), 16'h0);
        checkOutput("rd_alu_in1", 16'(alu_in1_c), 16'h0);
        checkOutput("rd_op_count", 16'(op_count_c), 16'h0);
        checkOutput("rd_req_ready_low", 16'(req_ready_c), 16'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("rd_req_ready_rel", 16'(req_ready_c), 16'h1);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("rd_no_rsp", 16'(rsp_valid_c), 16'h0);
        checkOutput("rd_op_count_post", 16'(op_count_c), 16'h0);

        // Counter wrap: 17 back-to-back ops at 6 cycles each on a 4-bit count
        req_valid_c = 1'b1;
        rsp_ready_c = 1'b1;
        for (int i = 0; i < 96; i++) tick();
        checkOutput("wrap_count_16", 16'(op_count_c), 16'h0);
        for (int i = 0; i < 6; i++) tick();
        req_valid_c = 1'b0;
        rsp_ready_c = 1'b0;
        checkOutput("wrap_count_17", 16'(op_count_c), 16'h1);
        checkOutput("wrap_req_ready", 16'(req_ready_c), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
